// File: rtl/puzzle_scrambler_pkg.sv
// Shared constants and state encoding for the LED puzzle scrambler.
package puzzle_scrambler_pkg;

    // Defused LED pattern; must match the defused-detect constant elsewhere.
    localparam logic [7:0] TARGET_DEFAULT = 8'hFF;

    // Default width of the step-count input (up to 15 steps).
    localparam int unsigned STEP_W_DEFAULT = 4;

    // Feedback taps of the 8-bit LFSR: bits 7, 5, 4, 3.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // Replacement for an all-zero seed, which would lock the LFSR up.
    localparam logic [7:0] LFSR_NZ_SEED = 8'h01;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StScramble = 2'd1,
        StCheck    = 2'd2,
        StLoad     = 2'd3
    } state_e;

endpackage

// File: rtl/puzzle_scrambler_if.sv
// Request/result bundle between the game controller and the scrambler.
interface puzzle_scrambler_if #(
    parameter int unsigned STEP_W = 4
);
    logic              start;
    logic [7:0]        seed;
    logic [STEP_W-1:0] steps;
    logic [7:0]        pattern;
    logic              load;
    logic              busy;
    logic              done;

    // Controller side: issues requests, consumes the pattern.
    modport master (
        output start, seed, steps,
        input  pattern, load, busy, done
    );

    // Scrambler side.
    modport slave (
        input  start, seed, steps,
        output pattern, load, busy, done
    );
endinterface

// File: rtl/puzzle_scrambler_lfsr8_step.sv
// Combinational next-state function of the 8-bit Fibonacci LFSR.
module lfsr8_step
    import puzzle_scrambler_pkg::*;
(
    input  logic [7:0] cur,
    output logic [7:0] nxt
);

    // Shift left, feeding the XOR of the tapped bits into bit 0.
    assign nxt = {cur[6:0], ^(cur & LFSR_TAPS)};

endmodule

// File: rtl/puzzle_scrambler.sv
// Builds a scrambled, solvable starting LED pattern by applying N self-inverse
// XOR/XNOR steps with an LFSR mask to the defused target, then pulses load.
module puzzle_scrambler
    import puzzle_scrambler_pkg::*;
#(
    parameter logic [7:0]  TARGET = TARGET_DEFAULT,
    parameter int unsigned STEP_W = STEP_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              reset,
    puzzle_scrambler_if.slave bus
);

    state_e            state_q;
    logic [7:0]        lfsr_q;
    logic [7:0]        pattern_q;
    logic [STEP_W-1:0] cnt_q;
    logic              load_q;
    logic              busy_q;
    logic              done_q;

    logic [7:0]        lfsr_nxt;
    logic [7:0]        mixed;

    lfsr8_step u_lfsr_step (
        .cur (lfsr_q),
        .nxt (lfsr_nxt)
    );

    assign mixed = pattern_q ^ lfsr_nxt;

    // Control FSM with all outputs registered.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            pattern_q <= 8'h00;
            lfsr_q    <= LFSR_NZ_SEED;
            cnt_q     <= '0;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        lfsr_q    <= (bus.seed == 8'h00) ? LFSR_NZ_SEED : bus.seed;
                        pattern_q <= TARGET;
                        cnt_q     <= bus.steps;
                        done_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= (bus.steps == '0) ? StCheck : StScramble;
                    end
                end
                StScramble: begin
                    lfsr_q    <= lfsr_nxt;
                    pattern_q <= lfsr_nxt[0] ? mixed : ~mixed;
                    cnt_q     <= cnt_q - STEP_W'(1);
                    if (cnt_q == STEP_W'(1)) begin
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    // Never hand the player an already-defused board.
                    if (pattern_q == TARGET) begin
                        pattern_q <= pattern_q ^ 8'h01;
                    end
                    state_q <= StLoad;
                end
                StLoad: begin
                    // First LOAD cycle raises the registered pulse, second retires it.
                    if (!load_q) begin
                        load_q <= 1'b1;
                    end else begin
                        load_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.pattern = pattern_q;
    assign bus.load    = load_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: doc/puzzle_scrambler.md
Name: puzzle_scrambler

Overview:
- Generates the scrambled starting LED pattern for the defusal game. It is the encoder counterpart of the key/op datapath that drives LEDs back toward the defused pattern.
- Starting from the defused target, it applies N pseudo-random self-inverse steps (XOR / XNOR with an LFSR mask). The result is always solvable with the game's own XOR/XNOR ops.
- Output pattern plus a one-cycle load pulse feed the LED register's parallel-load path at game start.

Parameters:
- TARGET, 8'hFF, defused LED pattern; must match the defused-detect constant.
- STEP_W, 4, width of the step-count input (max 15 steps).

Ports:
- CLK  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request a new scramble; sampled only in IDLE
- seed  in  8  LFSR seed, captured on accepted start
- steps  in  STEP_W  number of scramble steps, captured on accepted start
- pattern  out  8  scrambled pattern; valid while done=1
- load  out  1  one-cycle pulse, pattern valid for LED register load
- busy  out  1  high from accepted start until load cycle, inclusive
- done  out  1  high after load until next accepted start

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, pattern=8'h00, lfsr=8'h01, cnt=0, load=0, busy=0, done=0.
- States are IDLE, SCRAMBLE, CHECK, LOAD. DONE is not a separate state; it is IDLE with the done flag set.
- IDLE, start=1:
  - lfsr <= (seed==0) ? 8'h01 : seed
  - pattern <= TARGET
  - cnt <= steps
  - done <= 0, busy <= 1
  - next state = (steps==0) ? CHECK : SCRAMBLE
- SCRAMBLE, one step per cycle:
  - nl = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}; lfsr <= nl
  - if nl[0]=1: pattern <= pattern ^ nl
  - else: pattern <= ~(pattern ^ nl)
  - cnt <= cnt-1; go to CHECK when cnt==1
- CHECK, one cycle: if pattern==TARGET, pattern <= pattern ^ 8'h01, so the game never starts already defused. Next state is LOAD.
- LOAD, one cycle: load=1, busy=1. Next cycle: IDLE, busy=0, done=1, pattern held.
- Latency: start accepted at cycle 0 gives load high at cycle steps+2 and done high at cycle steps+3.
- start while busy=1: ignored, with no effect on seed, steps or cnt.
- start held high in IDLE after done: a new run begins immediately and done drops the next cycle.
- seed=0: substituted with 8'h01, since the all-zero state is the LFSR lock-up.
- Width: all arithmetic is 8-bit bitwise. cnt is STEP_W bits and never wraps, because it is only decremented while nonzero.
- Reset mid-operation: immediate return to the reset values. No load pulse is issued.
- load is registered, never combinational from start.

Decomposition:
- Shared package holds: TARGET default, the LFSR tap constant (bits 7,5,4,3), the state encoding (IDLE/SCRAMBLE/CHECK/LOAD, 2-bit), and the LFSR nonzero-seed constant 8'h01.
- One natural sub-module, lfsr8_step: purely combinational next-value function (8-bit in, 8-bit out). It is reused by the bench model.

Test Plan:
- Reset: assert reset=0 mid-SCRAMBLE (seed 8'h01, steps 5, reset at cycle 2) -> pattern=00, busy=0, done=0, load=0 immediately; no load pulse afterwards.
- Single step: seed 8'h01, steps 1 -> lfsr 02, pattern=~(FF^02)=8'h02; load pulse at cycle 3, done=1 at cycle 4, pattern=8'h02.
- Two steps: seed 8'h01, steps 2 -> intermediate 8'h02, final ~(02^04)=8'hF9; load at cycle 4.
- Zero steps / trivial result: seed 8'h55, steps 0 -> CHECK finds FF==TARGET, pattern=8'hFE; load at cycle 2.
- Zero seed: seed 8'h00, steps 1 -> behaves identically to seed 8'h01, pattern=8'h02.
- Busy guard: seed 8'h01, steps 4 accepted; pulse start with seed 8'hAA, steps 1 during busy -> ignored, exactly one load at cycle 6. Then start again in IDLE -> done drops the next cycle and a new run begins.
